// File: rtl/prbs15_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_pkg
// Brief    : Shared PRBS15 (x^15 + x^14 + 1) taps, checker state type and helpers.
// Revision : 1.0 - initial release
// ============================================================================
package prbs15_pkg;

  localparam int PRBS15_TAP_A = 14;
  localparam int PRBS15_TAP_B = 13;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs15_state_t;

  function automatic logic [3:0] prbs15_popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs15_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_checker_if
// Brief    : Byte stream and BER status bundle between a PRBS15 source and checker.
// Revision : 1.0 - initial release
// ============================================================================
interface prbs15_checker_if #(
  parameter int CNT_W = 32
);

  logic             valid;
  logic [7:0]       prbs_in;
  logic             clear_count;
  logic             locked;
  logic             byte_err;
  logic [7:0]       err_bits;
  logic [CNT_W-1:0] error_count;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output valid, prbs_in, clear_count,
    input  locked, byte_err, err_bits, error_count, byte_count
  );

  modport slave (
    input  valid, prbs_in, clear_count,
    output locked, byte_err, err_bits, error_count, byte_count
  );

endinterface
`default_nettype wire

// File: rtl/prbs15_step8.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_step8
// Brief    : Advances a PRBS15 history by eight bits; pred[7] is the first bit.
// Revision : 1.0 - initial release
// ============================================================================
module prbs15_step8
  import prbs15_pkg::*;
(
  input  logic [14:0] hist,
  output logic [7:0]  pred,
  output logic [14:0] hist_next
);

  logic [14:0] w_shift;

  always_comb begin
    w_shift = hist;
    pred    = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      pred[i] = w_shift[PRBS15_TAP_A] ^ w_shift[PRBS15_TAP_B];
      w_shift = {w_shift[13:0], pred[i]};
    end
    hist_next = w_shift;
  end

endmodule
`default_nettype wire

// File: rtl/prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_checker
// Brief    : Self-synchronising PRBS15 byte checker with lock detect and BER counters.
// Revision : 1.0 - initial release
// ============================================================================
module prbs15_checker
  import prbs15_pkg::*;
#(
  parameter int LOCK_BYTES   = 4,
  parameter int WINDOW_BYTES = 16,
  parameter int UNLOCK_ERR   = 8,
  parameter int CNT_W        = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  prbs15_checker_if.slave bus
);

  localparam logic [7:0]  c_lock_bytes = 8'(LOCK_BYTES);
  localparam logic [15:0] c_window     = 16'(WINDOW_BYTES);
  localparam logic [15:0] c_unlock     = 16'(UNLOCK_ERR);

  prbs15_state_t    r_state, w_state_nxt;
  logic [14:0]      r_hist, w_hist_nxt;
  logic [1:0]       r_fill, w_fill_nxt;
  logic [7:0]       r_ok, w_ok_nxt;
  logic [15:0]      r_win_err, w_win_err_nxt;
  logic [15:0]      r_win_bytes, w_win_bytes_nxt;
  logic             r_locked, w_locked_nxt;
  logic             r_byte_err, w_byte_err_nxt;
  logic [7:0]       r_err_bits, w_err_bits_nxt;
  logic [CNT_W-1:0] r_error_count, w_error_count_nxt;
  logic [CNT_W-1:0] r_byte_count, w_byte_count_nxt;

  logic [7:0]       w_pred;
  logic [14:0]      w_hist_pred;
  logic [14:0]      w_hist_rx;
  logic [7:0]       w_mask;
  logic [3:0]       w_pc;
  logic [15:0]      w_win_err_sum;
  logic [CNT_W:0]   w_err_sum;

  prbs15_step8 u_step8 (
    .hist      (r_hist),
    .pred      (w_pred),
    .hist_next (w_hist_pred)
  );

  assign w_hist_rx     = {r_hist[6:0], bus.prbs_in};
  assign w_mask        = w_pred ^ bus.prbs_in;
  assign w_pc          = prbs15_popcount8(w_mask);
  assign w_win_err_sum = r_win_err + 16'(w_pc);
  assign w_err_sum     = {1'b0, r_error_count} + (CNT_W+1)'(w_pc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= HUNT;
      r_hist        <= 15'd0;
      r_fill        <= 2'd0;
      r_ok          <= 8'd0;
      r_win_err     <= 16'd0;
      r_win_bytes   <= 16'd0;
      r_locked      <= 1'b0;
      r_byte_err    <= 1'b0;
      r_err_bits    <= 8'h00;
      r_error_count <= '0;
      r_byte_count  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_hist        <= w_hist_nxt;
      r_fill        <= w_fill_nxt;
      r_ok          <= w_ok_nxt;
      r_win_err     <= w_win_err_nxt;
      r_win_bytes   <= w_win_bytes_nxt;
      r_locked      <= w_locked_nxt;
      r_byte_err    <= w_byte_err_nxt;
      r_err_bits    <= w_err_bits_nxt;
      r_error_count <= w_error_count_nxt;
      r_byte_count  <= w_byte_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_hist_nxt        = r_hist;
    w_fill_nxt        = r_fill;
    w_ok_nxt          = r_ok;
    w_win_err_nxt     = r_win_err;
    w_win_bytes_nxt   = r_win_bytes;
    w_locked_nxt      = r_locked;
    w_byte_err_nxt    = 1'b0;
    w_err_bits_nxt    = 8'h00;
    w_error_count_nxt = r_error_count;
    w_byte_count_nxt  = r_byte_count;

    if (bus.valid) begin
      case (r_state)
        HUNT: begin
          w_hist_nxt = w_hist_rx;
          if (r_fill == 2'd1) begin
            w_state_nxt = VERIFY;
            w_fill_nxt  = 2'd0;
            w_ok_nxt    = 8'd0;
          end else begin
            w_fill_nxt = r_fill + 2'd1;
          end
        end

        VERIFY: begin
          // An all-zero history predicts zeros forever, so it must never build lock.
          w_hist_nxt = w_hist_rx;
          if ((w_mask != 8'h00) || (r_hist == 15'd0)) begin
            w_ok_nxt = 8'd0;
          end else if (r_ok == c_lock_bytes - 8'd1) begin
            w_state_nxt     = LOCKED;
            w_locked_nxt    = 1'b1;
            w_ok_nxt        = 8'd0;
            w_win_err_nxt   = 16'd0;
            w_win_bytes_nxt = 16'd0;
          end else begin
            w_ok_nxt = r_ok + 8'd1;
          end
        end

        LOCKED: begin
          // Free-running reference: received bits never re-seed the history here.
          w_hist_nxt        = w_hist_pred;
          w_err_bits_nxt    = w_mask;
          w_byte_err_nxt    = |w_mask;
          w_error_count_nxt = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
          w_byte_count_nxt  = (r_byte_count == '1) ? r_byte_count
                                                   : r_byte_count + CNT_W'(1);
          if (w_win_err_sum >= c_unlock) begin
            w_state_nxt     = HUNT;
            w_locked_nxt    = 1'b0;
            w_fill_nxt      = 2'd0;
            w_ok_nxt        = 8'd0;
            w_win_err_nxt   = 16'd0;
            w_win_bytes_nxt = 16'd0;
          end else if (r_win_bytes + 16'd1 == c_window) begin
            w_win_err_nxt   = 16'd0;
            w_win_bytes_nxt = 16'd0;
          end else begin
            w_win_err_nxt   = w_win_err_sum;
            w_win_bytes_nxt = r_win_bytes + 16'd1;
          end
        end

        default: begin
          w_state_nxt  = HUNT;
          w_locked_nxt = 1'b0;
        end
      endcase
    end

    if (bus.clear_count) begin
      w_error_count_nxt = '0;
      w_byte_count_nxt  = '0;
    end
  end

  assign bus.locked      = r_locked;
  assign bus.byte_err    = r_byte_err;
  assign bus.err_bits    = r_err_bits;
  assign bus.error_count = r_error_count;
  assign bus.byte_count  = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs15_checker
// Brief    : Bench for prbs15_checker: sequence-level reference model plus pinned literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs15_checker;

  localparam int LOCKN = 4;
  localparam int WIN   = 16;

  logic       clock    = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tb_valid = 1'b0;
  logic [7:0] tb_din   = 8'h00;
  logic       tb_clr   = 1'b0;
  bit         chk_en   = 1'b0;

  always #5 clock = ~clock;

  prbs15_checker_if #(.CNT_W(32)) bus0 ();
  prbs15_checker_if #(.CNT_W(4))  bus1 ();

  assign bus0.valid       = tb_valid;
  assign bus0.prbs_in     = tb_din;
  assign bus0.clear_count = tb_clr;
  assign bus1.valid       = tb_valid;
  assign bus1.prbs_in     = tb_din;
  assign bus1.clear_count = tb_clr;

  prbs15_checker #(.LOCK_BYTES(4), .WINDOW_BYTES(16), .UNLOCK_ERR(8), .CNT_W(32)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  prbs15_checker #(.LOCK_BYTES(4), .WINDOW_BYTES(16), .UNLOCK_ERR(255), .CNT_W(4)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the received/reference bit sequence obeys b[n] = b[n-15] ^ b[n-14].
  int        unl  [2];
  longint    cmax [2];
  bit        sq   [2][32768];
  int        sn   [2];
  int        ms   [2];
  int        mf   [2];
  int        mok  [2];
  int        mwe  [2];
  int        mwb  [2];
  longint    mec  [2];
  longint    mbc  [2];
  bit        e_lk [2];
  bit        e_be [2];
  logic [7:0] e_eb [2];

  function automatic bit sget(input int k, input int i);
    return sq[k][i & 32'h7FFF];
  endfunction

  task automatic spush(input int k, input bit b);
    sq[k][sn[k] & 32'h7FFF] = b;
    sn[k]++;
  endtask

  function automatic bit rec(input int k, input int n);
    return sget(k, n - 15) ^ sget(k, n - 14);
  endfunction

  task automatic model_reset(input int k);
    for (int i = 0; i < 15; i++) sq[k][i] = 1'b0;
    sn[k] = 15; ms[k] = 0; mf[k] = 0; mok[k] = 0; mwe[k] = 0; mwb[k] = 0;
    mec[k] = 0; mbc[k] = 0; e_lk[k] = 1'b0; e_be[k] = 1'b0; e_eb[k] = 8'h00;
  endtask

  task automatic model_step(input int k, input bit v, input logic [7:0] d, input bit c);
    logic [7:0] p;
    logic [7:0] m;
    bit         z;
    int         pc;
    p = 8'h00;
    e_eb[k] = 8'h00;
    e_be[k] = 1'b0;
    if (v) begin
      if (ms[k] == 0) begin
        for (int i = 7; i >= 0; i--) spush(k, d[i]);
        mf[k]++;
        if (mf[k] == 2) begin ms[k] = 1; mf[k] = 0; mok[k] = 0; end
      end else if (ms[k] == 1) begin
        z = 1'b1;
        for (int i = 1; i <= 15; i++) if (sget(k, sn[k] - i)) z = 1'b0;
        for (int j = 0; j < 8; j++) p[7-j] = rec(k, sn[k] + j);
        for (int i = 7; i >= 0; i--) spush(k, d[i]);
        if (z || (p != d)) mok[k] = 0;
        else begin
          mok[k]++;
          if (mok[k] == LOCKN) begin
            ms[k] = 2; e_lk[k] = 1'b1; mok[k] = 0; mwe[k] = 0; mwb[k] = 0;
          end
        end
      end else begin
        for (int j = 0; j < 8; j++) begin
          p[7-j] = rec(k, sn[k]);
          spush(k, p[7-j]);
        end
        m  = p ^ d;
        pc = $countones(m);
        e_eb[k] = m;
        e_be[k] = (m != 8'h00);
        mec[k] = (mec[k] + pc > cmax[k]) ? cmax[k] : mec[k] + pc;
        mbc[k] = (mbc[k] + 1  > cmax[k]) ? cmax[k] : mbc[k] + 1;
        mwe[k] += pc;
        mwb[k]++;
        if (mwe[k] >= unl[k]) begin
          ms[k] = 0; e_lk[k] = 1'b0; mf[k] = 0; mok[k] = 0; mwe[k] = 0; mwb[k] = 0;
        end else if (mwb[k] == WIN) begin
          mwe[k] = 0; mwb[k] = 0;
        end
      end
    end
    if (c) begin mec[k] = 0; mbc[k] = 0; end
  endtask

  always @(posedge clock) begin
    #1;
    if (chk_en) begin
      chk("cyc_locked0",   64'(bus0.locked),      64'(e_lk[0]));
      chk("cyc_byte_err0", 64'(bus0.byte_err),    64'(e_be[0]));
      chk("cyc_err_bits0", 64'(bus0.err_bits),    64'(e_eb[0]));
      chk("cyc_err_cnt0",  64'(bus0.error_count), 64'(mec[0]));
      chk("cyc_byte_cnt0", 64'(bus0.byte_count),  64'(mbc[0]));
      chk("cyc_locked1",   64'(bus1.locked),      64'(e_lk[1]));
      chk("cyc_byte_err1", 64'(bus1.byte_err),    64'(e_be[1]));
      chk("cyc_err_bits1", 64'(bus1.err_bits),    64'(e_eb[1]));
      chk("cyc_err_cnt1",  64'(bus1.error_count), 64'(mec[1]));
      chk("cyc_byte_cnt1", 64'(bus1.byte_count),  64'(mbc[1]));
    end
  end

  logic [14:0] g;

  task automatic gen(output logic [7:0] b);
    b = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      b[i] = g[14];
      g    = {g[13:0], g[14] ^ g[13]};
    end
  endtask

  task automatic cyc(input bit v, input logic [7:0] d, input bit c);
    @(negedge clock);
    tb_valid = v;
    tb_din   = d;
    tb_clr   = c;
    model_step(0, v, d, c);
    model_step(1, v, d, c);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n  = 1'b0;
    tb_valid = 1'b0;
    tb_clr   = 1'b0;
    tb_din   = 8'h00;
    model_reset(0);
    model_reset(1);
    #1;
    chk("rst_locked",   64'(bus0.locked),      64'd0);
    chk("rst_byte_err", 64'(bus0.byte_err),    64'd0);
    chk("rst_err_bits", 64'(bus0.err_bits),    64'd0);
    chk("rst_err_cnt",  64'(bus0.error_count), 64'd0);
    chk("rst_byte_cnt", 64'(bus0.byte_count),  64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    model_step(0, 1'b0, 8'h00, 1'b0);
    model_step(1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic lock_seq(input string tag);
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    settle();
    chk({tag, "_locked0_after5"}, 64'(bus0.locked), 64'd0);
    chk({tag, "_locked1_after5"}, 64'(bus1.locked), 64'd0);
    gen(b);
    cyc(1'b1, b, 1'b0);
    settle();
    chk({tag, "_locked0_after6"}, 64'(bus0.locked),     64'd1);
    chk({tag, "_locked1_after6"}, 64'(bus1.locked),     64'd1);
    chk({tag, "_byte_cnt_at_lock"}, 64'(bus0.byte_count), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         nv;
    bit         v;
    logic [7:0] m;

    unl[0] = 8;   cmax[0] = 64'hFFFF_FFFF;
    unl[1] = 255; cmax[1] = 15;
    model_reset(0);
    model_reset(1);

    do_reset();
    chk_en = 1'b1;

    // Lock acquisition from seed 7FFF.
    g = 15'h7FFF;
    gen(b); chk("gen_byte0", 64'(b), 64'hFF); cyc(1'b1, b, 1'b0);
    gen(b); chk("gen_byte1", 64'(b), 64'hFE); cyc(1'b1, b, 1'b0);
    g = 15'h7FFF;
    do_reset();
    lock_seq("acq");

    for (int i = 0; i < 1000; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    settle();
    chk("clean_err_cnt",  64'(bus0.error_count), 64'd0);
    chk("clean_byte_cnt", 64'(bus0.byte_count),  64'd1000);

    // Single-bit error.
    gen(b); cyc(1'b1, b ^ 8'h01, 1'b0);
    settle();
    chk("sbe_err_bits", 64'(bus0.err_bits),    64'h01);
    chk("sbe_byte_err", 64'(bus0.byte_err),    64'd1);
    chk("sbe_err_cnt",  64'(bus0.error_count), 64'd1);
    chk("sbe_locked",   64'(bus0.locked),      64'd1);
    gen(b); cyc(1'b1, b, 1'b0);
    settle();
    chk("sbe_pulse_end", 64'(bus0.byte_err), 64'd0);
    chk("sbe_bits_end",  64'(bus0.err_bits), 64'd0);

    gen(b); cyc(1'b1, b, 1'b1);
    settle();
    chk("clr_err_cnt",  64'(bus0.error_count), 64'd0);
    chk("clr_byte_cnt", 64'(bus0.byte_count),  64'd0);

    // Eight-bit error forces lock loss on the UNLOCK_ERR=8 instance only.
    gen(b); cyc(1'b1, b ^ 8'hFF, 1'b0);
    settle();
    chk("loss_locked0",  64'(bus0.locked),      64'd0);
    chk("loss_locked1",  64'(bus1.locked),      64'd1);
    chk("loss_err_cnt0", 64'(bus0.error_count), 64'd8);
    for (int i = 0; i < 5; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    settle();
    chk("relock_after5", 64'(bus0.locked), 64'd0);
    gen(b); cyc(1'b1, b, 1'b0);
    settle();
    chk("relock_after6",  64'(bus0.locked),      64'd1);
    chk("relock_err_cnt", 64'(bus0.error_count), 64'd8);

    // Saturation of the 4-bit counters, then clear wins over an errored byte.
    for (int i = 0; i < 20; i++) begin
      gen(b); cyc(1'b1, b ^ (8'h01 << $urandom_range(0, 7)), 1'b0);
    end
    settle();
    chk("sat_err_cnt1", 64'(bus1.error_count), 64'hF);
    chk("sat_locked1",  64'(bus1.locked),      64'd1);
    gen(b); cyc(1'b1, b ^ 8'h01, 1'b1);
    settle();
    chk("clrwin_err_cnt1",  64'(bus1.error_count), 64'd0);
    chk("clrwin_byte_cnt1", 64'(bus1.byte_count),  64'd0);
    chk("clrwin_err_bits1", 64'(bus1.err_bits),    64'h01);

    // Random valid gaps on a clean locked stream.
    for (int i = 0; i < 10; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    gen(b); cyc(1'b1, b, 1'b1);
    settle();
    chk("gap_pre_locked", 64'(bus0.locked), 64'd1);
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) != 0) begin
        gen(b); cyc(1'b1, b, 1'b0); nv++;
      end else begin
        cyc(1'b0, 8'($urandom), 1'b0);
      end
    end
    settle();
    chk("gap_byte_cnt", 64'(bus0.byte_count),  64'(nv));
    chk("gap_err_cnt",  64'(bus0.error_count), 64'd0);
    chk("gap_locked",   64'(bus0.locked),      64'd1);

    // Mixed random traffic: gaps, sparse bit errors, occasional clears.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 2) != 0);
      m = ($urandom_range(0, 9) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      if (v) begin gen(b); cyc(1'b1, b ^ m, ($urandom_range(0, 49) == 0)); end
      else cyc(1'b0, 8'($urandom), ($urandom_range(0, 49) == 0));
    end

    // Reset mid-lock, then an all-zero stream must never lock.
    for (int i = 0; i < 10; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    settle();
    chk("prereset_locked", 64'(bus0.locked), 64'd1);
    do_reset();
    g = 15'h0000;
    for (int i = 0; i < 100; i++) begin gen(b); cyc(1'b1, b, 1'b0); end
    settle();
    chk("zero_locked0",   64'(bus0.locked),      64'd0);
    chk("zero_locked1",   64'(bus1.locked),      64'd0);
    chk("zero_err_cnt0",  64'(bus0.error_count), 64'd0);
    chk("zero_byte_cnt0", 64'(bus0.byte_count),  64'd0);

    do_reset();
    g = 15'h7FFF;
    lock_seq("post_reset");

    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
    settle();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
